// File: rtl/simon_playback.sv
// Simon-game sequence playback: fetches colours from a synchronous sequence memory
// and plays each step as an LED/tone on-time followed by a gap. Option: SIMON_PLAYBACK_SKIP_LAST_GAP_EN.
module simon_playback #(
    parameter int MAX_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ticks_per_milli,
    input  logic              start,
    input  logic              abort,
    input  logic [5:0]        seq_len,
    input  logic [9:0]        on_ms,
    input  logic [9:0]        gap_ms,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [3:0]        led,
    output logic              tone_en,
    output logic [1:0]        tone_sel,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ON, S_GAP, S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] step_q;
    logic [1:0]        colour_q;
    logic [5:0]        len_q;
    logic [9:0]        on_q;
    logic [9:0]        gap_q;
    logic [15:0]       tick_q;
    logic [9:0]        ms_q;
    logic [3:0]        led_q;
    logic              tone_en_q;
    logic              busy_q;
    logic              done_q;

    logic [15:0] tpm_eff;
    logic [9:0]  on_eff;
    logic [9:0]  gap_eff;
    logic        tick_wrap;
    logic        on_end;
    logic        gap_end;
    logic [6:0]  step_cnt_d;
    logic        last_step;
    logic [5:0]  len_clamp;

    // Zero durations and a zero prescale are treated as one so every phase lasts at least a cycle.
    always_comb begin
        tpm_eff    = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
        on_eff     = (on_q == 10'd0) ? 10'd1 : on_q;
        gap_eff    = (gap_q == 10'd0) ? 10'd1 : gap_q;
        tick_wrap  = (tick_q == tpm_eff - 16'd1);
        on_end     = tick_wrap && (ms_q == on_eff - 10'd1);
        gap_end    = tick_wrap && (ms_q == gap_eff - 10'd1);
        step_cnt_d = 7'(step_q) + 7'd1;
        last_step  = (step_cnt_d == {1'b0, len_q});
        len_clamp  = (seq_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : seq_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            colour_q  <= 2'd0;
            len_q     <= 6'd0;
            on_q      <= 10'd0;
            gap_q     <= 10'd0;
            tick_q    <= 16'd0;
            ms_q      <= 10'd0;
            led_q     <= 4'd0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort && state_q != S_IDLE) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            led_q     <= 4'd0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        len_q  <= len_clamp;
                        on_q   <= on_ms;
                        gap_q  <= gap_ms;
                        step_q <= '0;
                        if (len_clamp != 6'd0) begin
                            state_q <= S_FETCH;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    colour_q  <= mem_data;
                    led_q     <= 4'b0001 << mem_data;
                    tone_en_q <= 1'b1;
                    tick_q    <= 16'd0;
                    ms_q      <= 10'd0;
                    state_q   <= S_ON;
                end
                S_ON: begin
                    if (on_end) begin
                        led_q     <= 4'd0;
                        tone_en_q <= 1'b0;
                        tick_q    <= 16'd0;
                        ms_q      <= 10'd0;
`ifdef SIMON_PLAYBACK_SKIP_LAST_GAP_EN
                        if (last_step) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_GAP;
                        end
`else
                        state_q <= S_GAP;
`endif
                    end else if (tick_wrap) begin
                        tick_q <= 16'd0;
                        ms_q   <= ms_q + 10'd1;
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        if (last_step) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            step_q  <= step_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end else if (tick_wrap) begin
                        tick_q <= 16'd0;
                        ms_q   <= ms_q + 10'd1;
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    step_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = step_q;
    assign led       = led_q;
    assign tone_en   = tone_en_q;
    assign tone_sel  = colour_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_simon_playback.sv
// Scoreboard bench for simon_playback: drivers push expected output-change events,
// a negedge monitor pops and compares each change the DUT presents.
module tb_simon_playback;

    localparam int W = 25;  // {rel[15:0], led[3:0], tone_en, tone_sel[1:0], done, busy}

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ticks_per_milli;
    logic        start;
    logic        abort;
    logic [5:0]  seq_len;
    logic [9:0]  on_ms;
    logic [9:0]  gap_ms;
    logic [4:0]  mem_addr;
    logic [1:0]  mem_data;
    logic [3:0]  led;
    logic        tone_en;
    logic [1:0]  tone_sel;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    logic [1:0]   mem [0:31];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           base     = 0;
    logic         mon_en   = 1'b0;
    logic [1:0]   exp_sel  = 2'd0;
    int           c_done;

    simon_playback #(.MAX_LEN(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(ticks_per_milli),
        .start(start), .abort(abort), .seq_len(seq_len), .on_ms(on_ms),
        .gap_ms(gap_ms), .mem_addr(mem_addr), .mem_data(mem_data), .led(led),
        .tone_en(tone_en), .tone_sel(tone_sel), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // clock / reset / memory model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_data <= mem[mem_addr];

    // monitor: every change of the watched outputs must match the queue head
    logic [8:0]   prev = 9'd0;
    logic [8:0]   cur;
    logic [W-1:0] obs;
    logic [W-1:0] expw;
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {led, tone_en, tone_sel, done, busy};
            if (cur != prev) begin
                obs = {16'(cyc - base), cur};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event got rel=%0d led=%b ten=%b sel=%0d done=%b busy=%b, required none",
                             obs[24:9], obs[8:5], obs[4], obs[3:2], obs[1], obs[0]);
                end else begin
                    expw = exp_q.pop_front();
                    if (obs !== expw) begin
                        n_fail++;
                        $display("FAIL event got rel=%0d led=%b ten=%b sel=%0d done=%b busy=%b, required rel=%0d led=%b ten=%b sel=%0d done=%b busy=%b",
                                 obs[24:9], obs[8:5], obs[4], obs[3:2], obs[1], obs[0],
                                 expw[24:9], expw[8:5], expw[4], expw[3:2], expw[1], expw[0]);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_ev(input int rel, input logic [3:0] l, input logic te,
                           input logic [1:0] s, input logic d, input logic b);
        exp_q.push_back({16'(rel), l, te, s, d, b});
    endtask

    // timing model: FETCH, LOAD, ON for on*tpm cycles, GAP for gap*tpm cycles, DONE
    task automatic expect_play(input int tpm, input int on, input int gap, input int len_in,
                               output int cd);
        int len, t_on, t_gap, c;
        len   = (len_in > 32) ? 32 : len_in;
        t_on  = ((on == 0) ? 1 : on) * ((tpm == 0) ? 1 : tpm);
        t_gap = ((gap == 0) ? 1 : gap) * ((tpm == 0) ? 1 : tpm);
        c  = 1;
        cd = 1;
        if (len != 0) push_ev(1, 4'd0, 1'b0, exp_sel, 1'b0, 1'b1);
        for (int i = 0; i < len; i++) begin
            exp_sel = mem[i];
            push_ev(c + 2, 4'b0001 << exp_sel, 1'b1, exp_sel, 1'b0, 1'b1);
`ifdef SIMON_PLAYBACK_SKIP_LAST_GAP_EN
            if (i == len - 1) begin
                cd = c + 2 + t_on;
                break;
            end
`endif
            push_ev(c + 2 + t_on, 4'd0, 1'b0, exp_sel, 1'b0, 1'b1);
            c  = c + 2 + t_on + t_gap;
            cd = c;
        end
        push_ev(cd, 4'd0, 1'b0, exp_sel, 1'b1, 1'b0);
        push_ev(cd + 1, 4'd0, 1'b0, exp_sel, 1'b0, 1'b0);
    endtask

    // driver tasks
    task automatic kick(input logic [15:0] tpm, input logic [9:0] on, input logic [9:0] gap,
                        input logic [5:0] len);
        @(negedge clk);
        ticks_per_milli = tpm;
        on_ms   = on;
        gap_ms  = gap;
        seq_len = len;
        start   = 1'b1;
        base    = cyc;
    endtask

    task automatic run(input int n, input int sp1, input int sp2, input int ab);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start = (k == sp1) || (k == sp2);
            abort = (k == ab);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        ticks_per_milli = 16'd0;
        start = 1'b0;
        abort = 1'b0;
        seq_len = 6'd0;
        on_ms = 10'd0;
        gap_ms = 10'd0;
        for (int i = 0; i < 32; i++) mem[i] = 2'(i * 3 + 1);
        mem[0] = 2'd2;
        mem[1] = 2'd1;

        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_tone_en", 32'(tone_en), 32'd0);
        chk("reset_tone_sel", 32'(tone_sel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Test 1: tpm=2 on=3 gap=1 len=2, colours 2 then 1
        push_ev(1,  4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        push_ev(3,  4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
        push_ev(9,  4'b0000, 1'b0, 2'd2, 1'b0, 1'b1);
        push_ev(13, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1);
`ifdef SIMON_PLAYBACK_SKIP_LAST_GAP_EN
        push_ev(19, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
        push_ev(20, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
`else
        push_ev(19, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1);
        push_ev(21, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
        push_ev(22, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
`endif
        exp_sel = 2'd1;
        kick(16'd2, 10'd3, 10'd1, 6'd2);
        run(26, 0, 0, 0);
        drain("t1_drain");
        chk("t1_idle_addr", 32'(mem_addr), 32'd0);

        // Test 2: empty sequence gives an immediate done, never busy
        expect_play(2, 3, 1, 0, c_done);
        kick(16'd2, 10'd3, 10'd1, 6'd0);
        run(6, 0, 0, 0);
        drain("t2_drain");

        // Test 3: abort in cycle 5 returns to IDLE at cycle 6, then a normal replay
        push_ev(1, 4'b0000, 1'b0, exp_sel, 1'b0, 1'b1);
        push_ev(3, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
        push_ev(6, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        exp_sel = 2'd2;
        kick(16'd2, 10'd3, 10'd1, 6'd2);
        run(12, 0, 0, 5);
        drain("t3_abort_drain");
        chk("t3_abort_addr", 32'(mem_addr), 32'd0);
        chk("t3_abort_busy", 32'(busy), 32'd0);
        expect_play(2, 3, 1, 2, c_done);
        kick(16'd2, 10'd3, 10'd1, 6'd2);
        run(c_done + 4, 0, 0, 0);
        drain("t3_replay_drain");

        // Test 4: start pulses while busy are ignored
        expect_play(2, 3, 1, 2, c_done);
        kick(16'd2, 10'd3, 10'd1, 6'd2);
        run(c_done + 4, 4, 10, 0);
        drain("t4_drain");

        // Test 5: all-zero timing collapses each phase to one cycle
        mem[0] = 2'd3;
        expect_play(0, 0, 0, 1, c_done);
        chk("t5_done_cycle", 32'(c_done),
`ifdef SIMON_PLAYBACK_SKIP_LAST_GAP_EN
            32'd4);
`else
            32'd5);
`endif
        kick(16'd0, 10'd0, 10'd0, 6'd1);
        run(c_done + 4, 0, 0, 0);
        drain("t5_drain");

        // Test 6: asynchronous reset mid-ON, then an over-long sequence clamps to 32 steps
        mem[0] = 2'd1;
        push_ev(1, 4'b0000, 1'b0, exp_sel, 1'b0, 1'b1);
        push_ev(3, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1);
        push_ev(6, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        kick(16'd2, 10'd3, 10'd1, 6'd2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_led", 32'(led), 32'd0);
        chk("t6_async_tone_en", 32'(tone_en), 32'd0);
        chk("t6_async_tone_sel", 32'(tone_sel), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_done", 32'(done), 32'd0);
        chk("t6_async_addr", 32'(mem_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        drain("t6_reset_drain");
        exp_sel = 2'd0;
        expect_play(1, 1, 1, 40, c_done);
        chk("t6_clamp_done_cycle", 32'(c_done),
`ifdef SIMON_PLAYBACK_SKIP_LAST_GAP_EN
            32'd128);
`else
            32'd129);
`endif
        kick(16'd1, 10'd1, 10'd1, 6'd40);
        run(c_done + 4, 0, 0, 0);
        drain("t6_clamp_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_playback.md
SIMON_PLAYBACK -- requirements
Module: simon_playback

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32: maximum sequence length in steps.
REQ-002 SHALL have parameter ADDR_W, default 5: sequence-memory address width, with 2**ADDR_W >= MAX_LEN.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port ticks_per_milli, input, 16: clk cycles per millisecond; quasi-static.
REQ-006 SHALL have port start, input, 1: request playback, sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1: cancel playback.
REQ-008 SHALL have port seq_len, input, 6: steps to play, 0..MAX_LEN; sampled with start.
REQ-009 SHALL have port on_ms, input, 10: LED/tone on time in ms; sampled with start.
REQ-010 SHALL have port gap_ms, input, 10: off time after each step in ms; sampled with start.
REQ-011 SHALL have port mem_addr, output, ADDR_W: current step index to sequence memory.
REQ-012 SHALL have port mem_data, input, 2: colour at mem_addr, valid one cycle after mem_addr (synchronous read).
REQ-013 SHALL have port led, output, 4: one-hot active LED, led = 1 << colour.
REQ-014 SHALL have port tone_en, output, 1: speaker tone enable.
REQ-015 SHALL have port tone_sel, output, 2: tone index, equal to colour.
REQ-016 SHALL have port busy, output, 1: playback in progress.
REQ-017 SHALL have port done, output, 1: one-cycle pulse on normal completion.

Function
REQ-018 SHALL implement states IDLE, FETCH, LOAD, ON, GAP, DONE.
REQ-019 IDLE SHALL, on start=1 and abort=0, latch seq_len/on_ms/gap_ms, clear step to 0, and go to FETCH if seq_len!=0, else DONE.
REQ-020 FETCH (1 cycle) SHALL drive mem_addr=step; LOAD (1 cycle) SHALL latch mem_data into colour register.
REQ-021 ON SHALL last exactly max(on_ms,1)*max(ticks_per_milli,1) cycles, with led=1<<colour, tone_en=1, tone_sel=colour.
REQ-022 GAP SHALL last exactly max(gap_ms,1)*max(ticks_per_milli,1) cycles with led=0 and tone_en=0, then step increments.
REQ-023 After GAP, SHALL go to DONE if step+1==seq_len, else FETCH.
REQ-024 Millisecond prescaler and ms counter SHALL clear on entry to ON and GAP so durations are exact; no drift across steps.
REQ-025 DONE SHALL last 1 cycle with done=1, busy=0, then return to IDLE.
REQ-026 busy SHALL be 1 in FETCH, LOAD, ON, GAP and 0 in IDLE and DONE.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, with led=0, tone_en=0, no done pulse; abort SHALL win over simultaneous start.
REQ-029 seq_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-030 mem_addr SHALL hold step in all states and be 0 in IDLE.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, step=0, colour=0, prescaler=0, led=0, tone_en=0, tone_sel=0, mem_addr=0, busy=0, done=0.
REQ-032 Reset asserted mid-playback SHALL abandon playback with no done pulse; operation SHALL resume on the first edge after release.

Configuration
REQ-033 With SIMON_PLAYBACK_SKIP_LAST_GAP_EN defined, the final step SHALL go from ON directly to DONE, omitting its GAP; without it, every step including the last SHALL have a GAP.

Verification
REQ-034 Test 1: tpm=2, on=3, gap=1, len=2, mem{0:2,1:1}, start at edge 0 -> FETCH at cycle 1, led=0100 cycles 3-8, led=0010 cycles 13-18, done at cycle 21 (cycle 19 with macro).
REQ-035 Test 2: len=0, start -> done pulse at cycle 1, led never set, busy stays 0.
REQ-036 Test 3: abort at cycle 5 of Test 1 -> IDLE at cycle 6, led=0, no done, later start plays normally.
REQ-037 Test 4: start pulsed at cycles 4 and 10 during Test 1 -> ignored, timing identical to Test 1.
REQ-038 Test 5: on=0, gap=0, tpm=0, len=1 -> ON 1 cycle, GAP 1 cycle, done at cycle 5.
REQ-039 Test 6: rst_n low mid-ON, asynchronously -> all outputs reset immediately; len=40 -> exactly 32 steps played.
